load_store_unit: RTL and testbench

- Sequential memory-stage successor to the combinational data-memory path in the execute unit.
- Accepts one load or store request per handshake and drives a ready/valid data-memory bus with byte strobes. Only one transaction is outstanding at a time.
- Performs lane alignment, sign/zero extension of read data, misalignment detection and a response timeout.
- Returns a single-cycle response toward write-back.

---
 rtl/load_store_unit.sv | 125 ++++++++++++
 tb/tb_load_store_unit.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// load_store_unit: one-outstanding load/store engine driving a ready/valid data-memory bus.
// Handles lane alignment, strobes, load extension, misalignment checks and a response timeout.
module load_store_unit #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_we,
  input  logic [2:0]        i_req_op,
  input  logic [XLEN-1:0]   i_req_addr,
  input  logic [XLEN-1:0]   i_req_wdata,
  output logic              o_rsp_valid,
  output logic [XLEN-1:0]   o_rsp_rdata,
  output logic              o_rsp_misalign,
  output logic              o_rsp_fault,
  output logic              o_dm_avalid,
  input  logic              i_dm_aready,
  output logic [XLEN-1:0]   o_dm_addr,
  output logic              o_dm_we,
  output logic [XLEN-1:0]   o_dm_wdata,
  output logic [XLEN/8-1:0] o_dm_wstrb,
  input  logic              i_dm_rvalid,
  input  logic [XLEN-1:0]   i_dm_rdata
);
  localparam int SB = XLEN / 8;
  localparam int OW = $clog2(SB);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ADDR, WAIT, RSP} state_t;
  state_t r_state, w_next;

  logic            r_we, r_mis, r_fault;
  logic [2:0]      r_op;
  logic [OW-1:0]   r_off;
  logic [XLEN-1:0] r_addr, r_wdata, r_rdata;
  logic [SB-1:0]   r_wstrb;
  logic [CW-1:0]   r_cnt;

  logic            w_acc, w_illegal, w_mis, w_to, w_done;
  logic [1:0]      w_size;
  logic [OW-1:0]   w_off;
  logic [7:0]      w_m8;
  logic [XLEN-1:0] w_keep, w_sh, w_ext;

  assign w_acc     = i_req_valid && o_req_ready;
  assign w_size    = i_req_op[1:0];
  assign w_off     = i_req_addr[OW-1:0];
  assign w_illegal = i_req_op == 3'b111 || (XLEN == 32 && (i_req_op == 3'b011 || i_req_op == 3'b110));
  // An illegal op reports fault only, so misalign is suppressed for it.
  assign w_mis     = !w_illegal && (w_size == 2'd1 ? i_req_addr[0] :
                                    w_size == 2'd2 ? |i_req_addr[1:0] :
                                    w_size == 2'd3 ? |i_req_addr[2:0] : 1'b0);
  assign w_m8      = w_size == 2'd0 ? 8'h01 : w_size == 2'd1 ? 8'h03 : w_size == 2'd2 ? 8'h0F : 8'hFF;
  assign w_keep    = w_size == 2'd0 ? XLEN'(8'hFF) : w_size == 2'd1 ? XLEN'(16'hFFFF) :
                     w_size == 2'd2 ? XLEN'(32'hFFFF_FFFF) : '1;
  assign w_sh      = i_dm_rdata >> {r_off, 3'b000};
  assign w_ext     = r_op == 3'b000 ? XLEN'($signed(w_sh[7:0]))  :
                     r_op == 3'b001 ? XLEN'($signed(w_sh[15:0])) :
                     r_op == 3'b010 ? XLEN'($signed(w_sh[31:0])) :
                     r_op == 3'b100 ? XLEN'(w_sh[7:0])  :
                     r_op == 3'b101 ? XLEN'(w_sh[15:0]) :
                     r_op == 3'b110 ? XLEN'(w_sh[31:0]) : w_sh;
  assign w_to      = r_cnt == CW'(TIMEOUT - 1);
  assign w_done    = r_state == WAIT && (i_dm_rvalid || w_to);

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_acc ? ((w_illegal || w_mis) ? RSP : ADDR) : IDLE;
      ADDR:    w_next = i_dm_aready ? WAIT : ADDR;
      WAIT:    w_next = w_done ? RSP : WAIT;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_we    <= 1'b0;
      r_op    <= '0;
      r_off   <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_wstrb <= '0;
      r_rdata <= '0;
      r_mis   <= 1'b0;
      r_fault <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (w_acc) begin
        r_we    <= i_req_we;
        r_op    <= i_req_op;
        r_off   <= w_off;
        r_addr  <= {i_req_addr[XLEN-1:OW], {OW{1'b0}}};
        r_wdata <= i_req_we ? (i_req_wdata & w_keep) << {w_off, 3'b000} : '0;
        r_wstrb <= i_req_we ? SB'(w_m8) << w_off : '0;
        r_rdata <= '0;
        r_mis   <= w_mis;
        r_fault <= w_illegal;
      end
      if (r_state == ADDR) r_cnt <= '0;
      else if (r_state == WAIT) r_cnt <= r_cnt + 1'b1;
      // rvalid takes priority over an expiring counter in the same cycle.
      if (w_done) begin
        r_rdata <= (i_dm_rvalid && !r_we) ? w_ext : '0;
        r_fault <= !i_dm_rvalid;
      end
    end
  end

  assign o_req_ready    = r_state == IDLE;
  assign o_dm_avalid    = r_state == ADDR;
  assign o_dm_addr      = o_dm_avalid ? r_addr : '0;
  assign o_dm_we        = o_dm_avalid && r_we;
  assign o_dm_wdata     = o_dm_avalid ? r_wdata : '0;
  assign o_dm_wstrb     = o_dm_avalid ? r_wstrb : '0;
  assign o_rsp_valid    = r_state == RSP;
  assign o_rsp_rdata    = o_rsp_valid ? r_rdata : '0;
  assign o_rsp_misalign = o_rsp_valid && r_mis;
  assign o_rsp_fault    = o_rsp_valid && r_fault;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed vectors for 32- and 64-bit instances with a short timeout.
module tb_load_store_unit;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        a_req_valid, a_req_ready, a_req_we, a_rsp_valid, a_rsp_mis, a_rsp_fault;
  logic        a_dm_avalid, a_dm_aready, a_dm_we, a_dm_rvalid;
  logic [2:0]  a_req_op;
  logic [31:0] a_req_addr, a_req_wdata, a_rsp_rdata, a_dm_addr, a_dm_wdata, a_dm_rdata;
  logic [3:0]  a_dm_wstrb;

  logic        b_req_valid, b_req_ready, b_req_we, b_rsp_valid, b_rsp_mis, b_rsp_fault;
  logic        b_dm_avalid, b_dm_aready, b_dm_we, b_dm_rvalid;
  logic [2:0]  b_req_op;
  logic [63:0] b_req_addr, b_req_wdata, b_rsp_rdata, b_dm_addr, b_dm_wdata, b_dm_rdata;
  logic [7:0]  b_dm_wstrb;

  load_store_unit #(.XLEN(32), .TIMEOUT(4)) u32 (
    .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(a_req_valid), .o_req_ready(a_req_ready),
    .i_req_we(a_req_we), .i_req_op(a_req_op), .i_req_addr(a_req_addr), .i_req_wdata(a_req_wdata),
    .o_rsp_valid(a_rsp_valid), .o_rsp_rdata(a_rsp_rdata), .o_rsp_misalign(a_rsp_mis),
    .o_rsp_fault(a_rsp_fault), .o_dm_avalid(a_dm_avalid), .i_dm_aready(a_dm_aready),
    .o_dm_addr(a_dm_addr), .o_dm_we(a_dm_we), .o_dm_wdata(a_dm_wdata), .o_dm_wstrb(a_dm_wstrb),
    .i_dm_rvalid(a_dm_rvalid), .i_dm_rdata(a_dm_rdata));

  load_store_unit #(.XLEN(64), .TIMEOUT(4)) u64 (
    .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(b_req_valid), .o_req_ready(b_req_ready),
    .i_req_we(b_req_we), .i_req_op(b_req_op), .i_req_addr(b_req_addr), .i_req_wdata(b_req_wdata),
    .o_rsp_valid(b_rsp_valid), .o_rsp_rdata(b_rsp_rdata), .o_rsp_misalign(b_rsp_mis),
    .o_rsp_fault(b_rsp_fault), .o_dm_avalid(b_dm_avalid), .i_dm_aready(b_dm_aready),
    .o_dm_addr(b_dm_addr), .o_dm_we(b_dm_we), .o_dm_wdata(b_dm_wdata), .o_dm_wstrb(b_dm_wstrb),
    .i_dm_rvalid(b_dm_rvalid), .i_dm_rdata(b_dm_rdata));

  int total = 0, bad = 0;

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask

  typedef struct {
    logic we; logic [2:0] op; logic [31:0] addr, wdata, rdata, e_addr, e_wdata;
    logic [3:0] e_strb; logic [31:0] e_rdata; logic e_mis, e_fault;
  } vec_t;

  task automatic run32(input vec_t v);
    @(negedge clk);
    a_req_valid = 1'b1; a_req_we = v.we; a_req_op = v.op; a_req_addr = v.addr; a_req_wdata = v.wdata;
    chk("ready", a_req_ready, 1);
    @(posedge clk); #1 a_req_valid = 1'b0;
    if (v.e_mis || v.e_fault) begin
      chk("early_valid", a_rsp_valid, 1);
      chk("no_avalid", a_dm_avalid, 0);
      chk("misalign", a_rsp_mis, v.e_mis);
      chk("fault", a_rsp_fault, v.e_fault);
      chk("err_rdata", a_rsp_rdata, 0);
    end else begin
      chk("avalid", a_dm_avalid, 1);
      chk("dm_addr", a_dm_addr, v.e_addr);
      chk("dm_we", a_dm_we, v.we);
      chk("dm_wdata", a_dm_wdata, v.e_wdata);
      chk("dm_wstrb", a_dm_wstrb, v.e_strb);
      chk("no_early_rsp", a_rsp_valid, 0);
      a_dm_aready = 1'b1;
      @(posedge clk); #1 a_dm_aready = 1'b0; a_dm_rvalid = 1'b1; a_dm_rdata = v.rdata;
      @(posedge clk); #1 a_dm_rvalid = 1'b0;
      chk("rsp_valid", a_rsp_valid, 1);
      chk("rsp_rdata", a_rsp_rdata, v.e_rdata);
      chk("rsp_mis", a_rsp_mis, 0);
      chk("rsp_fault", a_rsp_fault, 0);
    end
    @(posedge clk); #1;
    chk("rsp_one_cycle", a_rsp_valid, 0);
    chk("back_idle", a_req_ready, 1);
  endtask

  task automatic run64(input logic we, input logic [2:0] op, input logic [63:0] addr, wdata, rdata,
                       e_addr, e_wdata, input logic [7:0] e_strb, input logic [63:0] e_rdata);
    @(negedge clk);
    b_req_valid = 1'b1; b_req_we = we; b_req_op = op; b_req_addr = addr; b_req_wdata = wdata;
    @(posedge clk); #1 b_req_valid = 1'b0;
    chk("b_avalid", b_dm_avalid, 1);
    chk("b_dm_addr", b_dm_addr, e_addr);
    chk("b_dm_wdata", b_dm_wdata, e_wdata);
    chk("b_dm_wstrb", b_dm_wstrb, e_strb);
    b_dm_aready = 1'b1;
    @(posedge clk); #1 b_dm_aready = 1'b0; b_dm_rvalid = 1'b1; b_dm_rdata = rdata;
    @(posedge clk); #1 b_dm_rvalid = 1'b0;
    chk("b_rsp_valid", b_rsp_valid, 1);
    chk("b_rsp_rdata", b_rsp_rdata, e_rdata);
    chk("b_rsp_fault", b_rsp_fault, 0);
    @(posedge clk); #1;
  endtask

  task automatic req32(input logic we, input logic [2:0] op, input logic [31:0] addr, wdata);
    @(negedge clk);
    a_req_valid = 1'b1; a_req_we = we; a_req_op = op; a_req_addr = addr; a_req_wdata = wdata;
    @(posedge clk); #1 a_req_valid = 1'b0;
  endtask

  vec_t v[15];

  initial begin
    a_req_valid = 1'b0; a_req_we = 1'b0; a_req_op = '0; a_req_addr = '0; a_req_wdata = '0;
    a_dm_aready = 1'b0; a_dm_rvalid = 1'b0; a_dm_rdata = '0;
    b_req_valid = 1'b0; b_req_we = 1'b0; b_req_op = '0; b_req_addr = '0; b_req_wdata = '0;
    b_dm_aready = 1'b0; b_dm_rvalid = 1'b0; b_dm_rdata = '0;
    v[0]  = '{1'b0, 3'b000, 32'h1003, '0, 32'h80FF0000, 32'h1000, '0, 4'h0, 32'hFFFFFF80, 1'b0, 1'b0};
    v[1]  = '{1'b0, 3'b100, 32'h1003, '0, 32'h80FF0000, 32'h1000, '0, 4'h0, 32'h00000080, 1'b0, 1'b0};
    v[2]  = '{1'b1, 3'b001, 32'h2002, 32'h1234ABCD, 32'hFFFFFFFF, 32'h2000, 32'hABCD0000, 4'hC, '0, 1'b0, 1'b0};
    v[3]  = '{1'b0, 3'b010, 32'h3001, '0, '0, '0, '0, 4'h0, '0, 1'b1, 1'b0};
    v[4]  = '{1'b0, 3'b011, 32'h3000, '0, '0, '0, '0, 4'h0, '0, 1'b0, 1'b1};
    v[5]  = '{1'b0, 3'b001, 32'h4002, '0, 32'h80011234, 32'h4000, '0, 4'h0, 32'hFFFF8001, 1'b0, 1'b0};
    v[6]  = '{1'b0, 3'b101, 32'h4000, '0, 32'h8001F234, 32'h4000, '0, 4'h0, 32'h0000F234, 1'b0, 1'b0};
    v[7]  = '{1'b0, 3'b010, 32'h5004, '0, 32'hCAFEBABE, 32'h5004, '0, 4'h0, 32'hCAFEBABE, 1'b0, 1'b0};
    v[8]  = '{1'b1, 3'b000, 32'h6001, 32'hAABBCCDD, '0, 32'h6000, 32'h0000DD00, 4'h2, '0, 1'b0, 1'b0};
    v[9]  = '{1'b1, 3'b010, 32'h7000, 32'h11223344, '0, 32'h7000, 32'h11223344, 4'hF, '0, 1'b0, 1'b0};
    v[10] = '{1'b0, 3'b001, 32'h4001, '0, '0, '0, '0, 4'h0, '0, 1'b1, 1'b0};
    v[11] = '{1'b0, 3'b111, 32'h0000, '0, '0, '0, '0, 4'h0, '0, 1'b0, 1'b1};
    v[12] = '{1'b0, 3'b110, 32'h0000, '0, '0, '0, '0, 4'h0, '0, 1'b0, 1'b1};
    v[13] = '{1'b1, 3'b001, 32'h2001, 32'h0000FFFF, '0, '0, '0, 4'h0, '0, 1'b1, 1'b0};
    v[14] = '{1'b0, 3'b000, 32'h1001, '0, 32'h00007F00, 32'h1000, '0, 4'h0, 32'h0000007F, 1'b0, 1'b0};

    #2;
    chk("rst_ready", a_req_ready, 1);
    chk("rst_avalid", a_dm_avalid, 0);
    chk("rst_dm_addr", a_dm_addr, 0);
    chk("rst_wstrb", a_dm_wstrb, 0);
    chk("rst_rsp_valid", a_rsp_valid, 0);
    chk("rst_rsp_rdata", a_rsp_rdata, 0);
    @(negedge clk); rst_n = 1'b1;

    for (int i = 0; i < 15; i++) run32(v[i]);

    // address phase stalled 5 cycles, request attempts ignored meanwhile
    req32(1'b1, 3'b000, 32'h8003, 32'h0000005A);
    a_req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("hold_avalid", a_dm_avalid, 1);
      chk("hold_addr", a_dm_addr, 32'h8000);
      chk("hold_wdata", a_dm_wdata, 32'h5A000000);
      chk("hold_wstrb", a_dm_wstrb, 4'h8);
      chk("hold_not_ready", a_req_ready, 0);
      @(posedge clk); #1;
    end
    a_req_valid = 1'b0; a_dm_aready = 1'b1;
    @(posedge clk); #1 a_dm_aready = 1'b0;
    chk("hold_wait_norsp", a_rsp_valid, 0);
    @(posedge clk); #1 a_dm_rvalid = 1'b1;
    @(posedge clk); #1 a_dm_rvalid = 1'b0;
    chk("hold_rsp", a_rsp_valid, 1);
    chk("hold_store_rdata", a_rsp_rdata, 0);
    @(posedge clk); #1 chk("hold_rsp_end", a_rsp_valid, 0);

    // timeout with no rvalid
    req32(1'b0, 3'b010, 32'h9000, '0);
    a_dm_aready = 1'b1;
    @(posedge clk); #1 a_dm_aready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("to_wait", a_rsp_valid, 0);
      @(posedge clk); #1;
    end
    chk("to_rsp", a_rsp_valid, 1);
    chk("to_fault", a_rsp_fault, 1);
    chk("to_mis", a_rsp_mis, 0);
    chk("to_rdata", a_rsp_rdata, 0);
    @(posedge clk); #1;

    // rvalid on the expiry cycle wins
    req32(1'b0, 3'b010, 32'h9000, '0);
    a_dm_aready = 1'b1;
    @(posedge clk); #1 a_dm_aready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("exp_wait", a_rsp_valid, 0);
      @(posedge clk); #1;
    end
    a_dm_rvalid = 1'b1; a_dm_rdata = 32'h12345678;
    @(posedge clk); #1 a_dm_rvalid = 1'b0;
    chk("exp_rsp", a_rsp_valid, 1);
    chk("exp_fault", a_rsp_fault, 0);
    chk("exp_rdata", a_rsp_rdata, 32'h12345678);
    @(posedge clk); #1;

    // stray rvalid while idle
    a_dm_rvalid = 1'b1;
    @(posedge clk); #1 a_dm_rvalid = 1'b0;
    chk("stray_rvalid", a_rsp_valid, 0);
    chk("stray_ready", a_req_ready, 1);

    // reset during ADDR drops avalid asynchronously
    req32(1'b0, 3'b010, 32'hA000, '0);
    chk("radr_avalid", a_dm_avalid, 1);
    #2 rst_n = 1'b0;
    #1 chk("radr_drop", a_dm_avalid, 0);
    @(negedge clk); rst_n = 1'b1;

    // reset during WAIT
    req32(1'b0, 3'b010, 32'hA000, '0);
    a_dm_aready = 1'b1;
    @(posedge clk); #1 a_dm_aready = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk("rwait_ready", a_req_ready, 1);
    chk("rwait_rsp", a_rsp_valid, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1 chk("rwait_no_rsp", a_rsp_valid, 0);
    @(posedge clk); #1 chk("rwait_no_rsp2", a_rsp_valid, 0);

    run64(1'b0, 3'b110, 64'h1004, '0, 64'hDEADBEEF_00000000, 64'h1000, '0, 8'h00, 64'h00000000_DEADBEEF);
    run64(1'b0, 3'b010, 64'h1004, '0, 64'hDEADBEEF_00000000, 64'h1000, '0, 8'h00, 64'hFFFFFFFF_DEADBEEF);
    run64(1'b0, 3'b011, 64'h2000, '0, 64'h01234567_89ABCDEF, 64'h2000, '0, 8'h00, 64'h01234567_89ABCDEF);
    run64(1'b1, 3'b011, 64'h3000, 64'h11223344_55667788, '1, 64'h3000, 64'h11223344_55667788, 8'hFF, '0);
    run64(1'b1, 3'b001, 64'h4006, 64'hFFFFFFFF_FFFFBEEF, '0, 64'h4000, 64'hBEEF0000_00000000, 8'hC0, '0);
    run64(1'b0, 3'b000, 64'h5007, '0, 64'h7F000000_00000000, 64'h5000, '0, 8'h00, 64'h7F);

    @(negedge clk);
    b_req_valid = 1'b1; b_req_we = 1'b0; b_req_op = 3'b011; b_req_addr = 64'h6004;
    @(posedge clk); #1 b_req_valid = 1'b0;
    chk("b_d_mis_valid", b_rsp_valid, 1);
    chk("b_d_mis", b_rsp_mis, 1);
    chk("b_d_mis_fault", b_rsp_fault, 0);
    chk("b_d_mis_noavalid", b_dm_avalid, 0);
    @(posedge clk); #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
